// File: rtl/ram8x8_ctrl_if.sv
// ram8x8_ctrl_if: bundles the command handshake and the RAM port of the
// ram8x8 sequencer.
//   command side : req, cmd, addr, wdata -> ack, err, rdata, busy
//   RAM side     : ram_a, ram_entrada, ram_rw -> ram_s
// The slave modport is the controller's view. The master modport is the
// environment's view: the requester together with the RAM it drives.
interface ram8x8_ctrl_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
);
  logic              req;
  logic [1:0]        cmd;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic              err;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic [ADDR_W-1:0] ram_a;
  logic [DATA_W-1:0] ram_entrada;
  logic              ram_rw;
  logic [DATA_W-1:0] ram_s;

  modport slave (
    input  req, cmd, addr, wdata, ram_s,
    output ack, err, rdata, busy, ram_a, ram_entrada, ram_rw
  );

  modport master (
    output req, cmd, addr, wdata, ram_s,
    input  ack, err, rdata, busy, ram_a, ram_entrada, ram_rw
  );
endinterface

// File: rtl/ram8x8_ctrl.sv
// ram8x8_ctrl: turns single-cycle read/write/fill commands into timed RAM
// cycles on an 8x8 RAM port.
//   clk   : system clock, rising edge
//   clear : asynchronous active-low reset
//   bus   : ram8x8_ctrl_if.slave
//           (command handshake req/cmd/addr/wdata -> ack/err/rdata/busy,
//            RAM port ram_a/ram_entrada/ram_rw <- ram_s)
// cmd: 00 read, 01 write, 10 fill (mem[k] = wdata + k for all k), 11 reserved.
module ram8x8_ctrl #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) (
  input  logic         clk,
  input  logic         clear,
  ram8x8_ctrl_if.slave bus
);

  localparam logic [1:0] CMD_RD   = 2'b00;
  localparam logic [1:0] CMD_WR   = 2'b01;
  localparam logic [1:0] CMD_FILL = 2'b10;
  localparam logic [1:0] CMD_RSV  = 2'b11;
  localparam logic [ADDR_W-1:0] K_LAST = '1;

  typedef enum logic [2:0] {
    IDLE, W_SETUP, W_STROBE, W_HOLD, R_ADDR, R_SAMPLE, DONE
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        cmd_q, cmd_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] k_q, k_d;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  logic [DATA_W-1:0] ram_wd_q, ram_wd_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] k_nxt;

  assign k_nxt = k_q + 1'b1;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q  <= IDLE;
      cmd_q    <= CMD_RD;
      wdata_q  <= '0;
      k_q      <= '0;
      ram_a_q  <= '0;
      ram_wd_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      wdata_q  <= wdata_d;
      k_q      <= k_d;
      ram_a_q  <= ram_a_d;
      ram_wd_q <= ram_wd_d;
      rdata_q  <= rdata_d;
    end
  end

  // RAM address/data registers are loaded only on the transition into
  // W_SETUP or R_ADDR, so they are stable for the whole strobe window.
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    wdata_d  = wdata_q;
    k_d      = k_q;
    ram_a_d  = ram_a_q;
    ram_wd_d = ram_wd_q;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          cmd_d   = bus.cmd;
          wdata_d = bus.wdata;
          case (bus.cmd)
            CMD_RD: begin
              ram_a_d = bus.addr;
              state_d = R_ADDR;
            end
            CMD_WR: begin
              ram_a_d  = bus.addr;
              ram_wd_d = bus.wdata;
              state_d  = W_SETUP;
            end
            CMD_FILL: begin
              k_d      = '0;
              ram_a_d  = '0;
              ram_wd_d = bus.wdata;
              state_d  = W_SETUP;
            end
            default: state_d = DONE;
          endcase
        end
      end
      W_SETUP:  state_d = W_STROBE;
      W_STROBE: state_d = W_HOLD;
      W_HOLD: begin
        // Fill walks k up to the last address and then stops; no wrap.
        if (cmd_q == CMD_FILL && k_q != K_LAST) begin
          k_d      = k_nxt;
          ram_a_d  = k_nxt;
          ram_wd_d = wdata_q + DATA_W'(k_nxt);
          state_d  = W_SETUP;
        end else begin
          state_d = DONE;
        end
      end
      R_ADDR: state_d = R_SAMPLE;
      R_SAMPLE: begin
        rdata_d = bus.ram_s;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobe and handshake outputs decode straight off the state register so
  // an asynchronous reset drops them without waiting for a clock edge.
  assign bus.ack         = (state_q == DONE);
  assign bus.err         = (state_q == DONE) && (cmd_q == CMD_RSV);
  assign bus.busy        = (state_q != IDLE);
  assign bus.ram_rw      = (state_q == W_STROBE);
  assign bus.ram_a       = ram_a_q;
  assign bus.ram_entrada = ram_wd_q;
  assign bus.rdata       = rdata_q;

endmodule

// File: tb/tb_ram8x8_ctrl.sv
module tb_ram8x8_ctrl;
  localparam int AW = 3;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic clear = 1'b0;
  always #5 clk = ~clk;

  ram8x8_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  ram8x8_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .clear(clear), .bus(bus));

  // One record per clock cycle after accept: what the outputs must look like.
  typedef struct packed {
    logic          busy, ack, err, rw, set_a, set_d, rd_upd;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] rd;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] ref_mem [8];
  logic [DW-1:0] init_mem[8];
  logic [DW-1:0] ram_mem [8];
  logic          load = 1'b0;
  int            wr_cnt = 0;
  int            vectors = 0;
  int            miscompares = 0;
  logic [AW-1:0] exp_a = '0;
  logic [DW-1:0] exp_d = '0;
  logic [DW-1:0] exp_rdata = '0;

  // Behavioural RAM: synchronous write while ram_rw, combinational read.
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 8; i++) ram_mem[i] <= init_mem[i];
    end else if (bus.ram_rw) begin
      ram_mem[bus.ram_a] <= bus.ram_entrada;
      wr_cnt <= wr_cnt + 1;
    end
  end
  assign bus.ram_s = ram_mem[bus.ram_a];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : cmp
    exp_t e;
    if (!clear) begin
      chk("rst_ack", {31'b0, bus.ack}, 0);
      chk("rst_err", {31'b0, bus.err}, 0);
      chk("rst_busy", {31'b0, bus.busy}, 0);
      chk("rst_rw", {31'b0, bus.ram_rw}, 0);
      chk("rst_ram_a", {29'b0, bus.ram_a}, 0);
      chk("rst_ram_d", {24'b0, bus.ram_entrada}, 0);
      chk("rst_rdata", {24'b0, bus.rdata}, 0);
    end else begin
      e = '0;
      if (q.size() > 0) e = q.pop_front();
      if (e.set_a) exp_a = e.a;
      if (e.set_d) exp_d = e.d;
      if (e.rd_upd) exp_rdata = e.rd;
      chk("ack", {31'b0, bus.ack}, {31'b0, e.ack});
      chk("err", {31'b0, bus.err}, {31'b0, e.err});
      chk("busy", {31'b0, bus.busy}, {31'b0, e.busy});
      chk("ram_rw", {31'b0, bus.ram_rw}, {31'b0, e.rw});
      chk("ram_a", {29'b0, bus.ram_a}, {29'b0, exp_a});
      chk("ram_entrada", {24'b0, bus.ram_entrada}, {24'b0, exp_d});
      chk("rdata", {24'b0, bus.rdata}, {24'b0, exp_rdata});
    end
  end

  task automatic push_w(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    e = '0; e.busy = 1; e.set_a = 1; e.set_d = 1; e.a = a; e.d = d;
    q.push_back(e);                       // setup
    e.set_a = 0; e.set_d = 0; e.rw = 1;
    q.push_back(e);                       // strobe
    e.rw = 0;
    q.push_back(e);                       // hold
  endtask

  task automatic push_done(input logic err, input logic rd_upd, input logic [DW-1:0] rd);
    exp_t e;
    e = '0; e.busy = 1; e.ack = 1; e.err = err; e.rd_upd = rd_upd; e.rd = rd;
    q.push_back(e);
  endtask

  // Issue one command in an IDLE cycle; afterwards scramble the inputs every
  // cycle (req held high if hold) until the DONE cycle has been reached.
  task automatic issue(input logic [1:0] c, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input bit hold);
    int n, w0, nw;
    exp_t e;
    @(negedge clk);
    bus.req = 1'b1; bus.cmd = c; bus.addr = a; bus.wdata = wd;
    w0 = wr_cnt;
    @(posedge clk); #1;
    case (c)
      2'b00: begin
        e = '0; e.busy = 1; e.set_a = 1; e.a = a;
        q.push_back(e);
        e.set_a = 0;
        q.push_back(e);
        push_done(1'b0, 1'b1, ref_mem[a]);
        n = 3; nw = 0;
      end
      2'b01: begin
        push_w(a, wd);
        push_done(1'b0, 1'b0, '0);
        ref_mem[a] = wd;
        n = 4; nw = 1;
      end
      2'b10: begin
        for (int k = 0; k < 8; k++) begin
          push_w(AW'(k), wd + DW'(k));
          ref_mem[k] = wd + DW'(k);
        end
        push_done(1'b0, 1'b0, '0);
        n = 25; nw = 8;
      end
      default: begin
        push_done(1'b1, 1'b0, '0);
        n = 1; nw = 0;
      end
    endcase
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.req   = hold ? 1'b1 : 1'($urandom_range(0, 1));
      bus.cmd   = 2'($urandom);
      bus.addr  = AW'($urandom);
      bus.wdata = DW'($urandom);
    end
    chk("strobe_count", wr_cnt - w0, nw);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.req = 1'b0;
    end
  endtask

  // Fill that is reset while the k=4 strobe is on the RAM port.
  task automatic fill_abort(input logic [DW-1:0] wd);
    int w0;
    @(negedge clk);
    bus.req = 1'b1; bus.cmd = 2'b10; bus.addr = '0; bus.wdata = wd;
    w0 = wr_cnt;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) push_w(AW'(k), wd + DW'(k));
    begin
      exp_t e;
      e = '0; e.busy = 1; e.set_a = 1; e.set_d = 1; e.a = 3'd4; e.d = wd + 8'd4;
      q.push_back(e);
    end
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      bus.req = 1'b0; bus.wdata = DW'($urandom); bus.addr = AW'($urandom);
    end
    @(posedge clk); #2;
    chk("abort_pre_rw", {31'b0, bus.ram_rw}, 1);
    clear = 1'b0;
    #1;
    q.delete();
    exp_a = '0; exp_d = '0; exp_rdata = '0;
    chk("abort_rw", {31'b0, bus.ram_rw}, 0);
    chk("abort_busy", {31'b0, bus.busy}, 0);
    chk("abort_ack", {31'b0, bus.ack}, 0);
    chk("abort_ram_a", {29'b0, bus.ram_a}, 0);
    for (int k = 0; k < 4; k++) ref_mem[k] = wd + DW'(k);
    @(posedge clk); #2;
    clear = 1'b1;
    chk("abort_strobes", wr_cnt - w0, 4);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req = 1'b0; bus.cmd = '0; bus.addr = '0; bus.wdata = '0;
    for (int i = 0; i < 8; i++) begin
      init_mem[i] = DW'($urandom);
      ref_mem[i]  = init_mem[i];
    end
    @(negedge clk); load = 1'b1;
    @(negedge clk); load = 1'b0;
    @(negedge clk); #1;
    chk("reset_busy", {31'b0, bus.busy}, 0);
    clear = 1'b1;

    // write, then read back
    issue(2'b01, 3'd3, 8'h5A, 1'b0);
    issue(2'b00, 3'd3, 8'h00, 1'b0);
    chk("t2_rdata", {24'b0, bus.rdata}, 32'h5A);
    idle(2);

    // fill with wrap-around data, then read addr 2
    issue(2'b10, 3'd0, 8'hFE, 1'b0);
    chk("t3_model_k7", {24'b0, ref_mem[7]}, 32'h05);
    issue(2'b00, 3'd2, 8'h77, 1'b0);
    chk("t3_rdata", {24'b0, bus.rdata}, 32'h00);

    // reserved command leaves rdata alone
    issue(2'b11, 3'd5, 8'h99, 1'b0);
    chk("t4_rdata", {24'b0, bus.rdata}, 32'h00);
    idle(1);

    // reset in the middle of a fill, then read every location
    fill_abort(8'h10);
    for (int i = 0; i < 8; i++) begin
      issue(2'b00, AW'(i), 8'h00, 1'b0);
      if (i == 3) chk("t5_addr3", {24'b0, bus.rdata}, 32'h13);
      if (i == 4) chk("t5_addr4", {24'b0, bus.rdata}, 32'h02);
    end

    // req held continuously, inputs scrambled mid-operation
    issue(2'b01, 3'd5, 8'hC3, 1'b1);
    issue(2'b01, 3'd6, 8'h3C, 1'b1);
    issue(2'b00, 3'd5, 8'h00, 1'b1);
    chk("t6_rdata", {24'b0, bus.rdata}, 32'hC3);
    issue(2'b00, 3'd6, 8'h00, 1'b1);
    chk("t6_rdata2", {24'b0, bus.rdata}, 32'h3C);
    idle(1);

    // random traffic
    for (int i = 0; i < 60; i++) begin
      issue(2'($urandom), AW'($urandom), DW'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(2);

    for (int i = 0; i < 8; i++) chk("ram_contents", {24'b0, ram_mem[i]}, {24'b0, ref_mem[i]});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ram8x8_ctrl.md
Name: ram8x8_ctrl

Overview:
- Sequencing initiator that drives the 8x8 RAM port (address, data-in, rw) and reads its data-out.
- Turns a single-cycle request/acknowledge command interface into correctly timed RAM write strobes and read samples.
- Adds a block-fill command that writes all 8 locations in one operation.
- Sits between the test/datapath logic and one ram8x8 instance.

Parameters:
ADDR_W, 3, RAM address width (depth = 2**ADDR_W)
DATA_W, 8, RAM word width

Ports:
clk  input  1  system clock; all state changes on rising edge
clear  input  1  reset; one clock; reset is asynchronous and active-low
req  input  1  command request; sampled only in IDLE
cmd  input  2  00 read, 01 write, 10 fill, 11 reserved
addr  input  ADDR_W  target address (read/write)
wdata  input  DATA_W  write data; fill base value
ack  output  1  one-cycle pulse: command complete
err  output  1  valid with ack; 1 = reserved cmd
rdata  output  DATA_W  read result; held until next read completes
busy  output  1  high whenever state != IDLE
ram_a  output  ADDR_W  RAM address
ram_entrada  output  DATA_W  RAM data-in
ram_rw  output  1  RAM write enable (1 = write)
ram_s  input  DATA_W  RAM data-out (combinational from ram_a)

Behaviour:
- Reset (clear=0, async): state=IDLE; ack, err, busy, ram_rw = 0; rdata, ram_a, ram_entrada = 0; fill counter = 0. Forced low immediately, no clock edge needed.
- Reset mid-operation: the operation is abandoned and no ack is issued. ram_rw drops immediately, so no partial strobe survives. RAM contents are not touched.
- States: IDLE, W_SETUP, W_STROBE, W_HOLD, R_ADDR, R_SAMPLE, DONE.
- IDLE with req=1 at edge E0: latch cmd, addr and wdata into internal registers. Later input changes are ignored.
- Write:
  - W_SETUP: ram_a/ram_entrada driven, ram_rw=0.
  - W_STROBE: ram_rw=1 for exactly one cycle.
  - W_HOLD: ram_rw=0, address/data still held.
  - DONE: ack=1.
  - ack is high in the cycle after edge E0+3.
- Read:
  - R_ADDR: ram_a driven, ram_rw=0.
  - R_SAMPLE: rdata <= ram_s on the edge leaving R_SAMPLE.
  - DONE: ack=1, 2 cycles after E0.
- Fill:
  - Counter k runs 0..7.
  - Each k uses the W_SETUP/W_STROBE/W_HOLD triplet with ram_a=k and ram_entrada=(wdata+k) mod 2**DATA_W.
  - After k=7 HOLD, go to DONE.
  - 24 write cycles in total; ack high in the cycle after edge E0+24.
  - Address does not wrap past 7; the counter stops.
- Reserved cmd (11): IDLE -> DONE directly. ack=1 and err=1 for that cycle; no RAM activity (ram_rw stays 0).
- DONE -> IDLE unconditionally.
  - A req present during the DONE cycle is not accepted.
  - It is accepted on the next edge, in IDLE.
- req while busy: ignored, not queued.
- ram_rw is 1 only in W_STROBE. ram_a/ram_entrada change only on entry to W_SETUP/R_ADDR, never while ram_rw=1.
- err=0 whenever ack=0.
- rdata is unchanged by write, fill, and reserved commands.
- Idle outputs: ram_a/ram_entrada keep their last driven value; ram_rw=0.

Test Plan:
1. Reset then write 8'h5A to addr 3 -> ram_rw high for exactly 1 cycle with ram_a=3, ram_entrada=8'h5A; ack 4 cycles after accept; busy high through DONE.
2. Read addr 3 after (1) -> rdata=8'h5A, ack 3 cycles after accept, ram_rw never asserted, err=0.
3. Fill with wdata=8'hFE -> 8 strobes at addr 0..7 with data FE,FF,00,01,02,03,04,05 (wraps mod 256); ack at cycle 25; reading addr 2 then returns 8'h00.
4. cmd=11 -> ack and err both high one cycle after accept; ram_rw stays 0; rdata unchanged.
5. Pulse clear low during fill at k=4 in W_STROBE -> ram_rw falls with no clock edge, no ack; after release, reads show addr 0..3 written and addr 4..7 still holding the previous contents (k=4 not committed).
6. Hold req=1 continuously with a write command, changing addr/wdata mid-operation -> only the latched values are written; exactly one IDLE cycle separates DONE and the next accept.
